sdcard_block_reader: RTL and testbench
======================================

// Module: sdcard_block_reader
// PURPOSE
//  SPI-mode SD card single-block read engine. After the command layer has issued
//  CMD17, it clocks the card, hunts for the 0xFE data token, and shifts in 512 data
//  bytes plus CRC16. Each data byte is presented as a one-cycle strobe with a byte
//  address, feeding the IDE data buffer's sdcard_dma_data/addr/strobe inputs.
//  Reports done, CRC, token and timeout status to the RISC-V.
// PARAMETERS
//  CLKDIV        2     sclk half-period in clk cycles (>=1); sclk period = 2*CLKDIV
//  TOKEN_TIMEOUT 4096  max bytes clocked in WAIT_TOKEN before timeout (<=65535)
// PORTS
//  clk            in   1  system clock
//  reset_         in   1  asynchronous, active-low reset
//  start          in   1  one-cycle pulse: begin block read (ignored while busy)
//  abort          in   1  one-cycle pulse: cancel read, return to IDLE
//  sd_sclk        out  1  SPI clock to card, mode 0 (idle low)
//  sd_mosi        out  1  SPI data to card; constant 1 in this block
//  sd_miso        in   1  SPI data from card, sampled on sd_sclk rising edge
//  dma_data       out  8  received data byte, valid with dma_strobe
//  dma_addr       out  9  byte index 0..511 of dma_data
//  dma_strobe     out  1  one-cycle pulse per received data byte
//  busy           out  1  high in any state other than IDLE
//  done           out  1  one-cycle pulse when a read terminates (ok or error)
//  crc_error      out  1  sticky: received CRC16 != computed CRC16
//  token_error    out  1  sticky: non-0xFF, non-0xFE byte seen while hunting token
//  timeout_error  out  1  sticky: TOKEN_TIMEOUT bytes without a token
// BEHAVIOUR
//  Reset (reset_ low, async): state IDLE; sd_sclk=0, sd_mosi=1, dma_data=0,
//   dma_addr=0, dma_strobe=0, busy=0, done=0, all error flags 0, counters 0.
//  Bit engine: divider counts CLKDIV clk cycles per sclk phase; sclk toggles only
//   outside IDLE. Shift register loads sd_miso MSB-first in the clk cycle sclk
//   rises. Byte completes on 8th rising edge; sclk returns low before next byte.
//  States:
//   IDLE       start -> clear error flags, byte/timeout counters; -> WAIT_TOKEN.
//   WAIT_TOKEN per byte: 0xFE -> DATA (addr=0, crc=0x0000); 0xFF -> count++, if
//              count==TOKEN_TIMEOUT -> timeout_error=1, DONE; else token_error=1,
//              DONE.
//   DATA       per byte: dma_data<=byte, dma_addr<=index, dma_strobe=1 for exactly
//              one cycle, the clk cycle after the 8th rising edge; CRC updated;
//              index 511 -> CRC_HI. Index is 9 bits, never wraps inside a block.
//   CRC_HI/LO  receive CRC MSB then LSB (no strobe). After LSB: crc_error set if
//              mismatch; -> DONE.
//   DONE       done=1 one cycle, sclk low; -> IDLE next cycle.
//  CRC: CRC16-CCITT, poly 0x1021, init 0x0000, MSB-first over 512 data bytes only.
//  start while busy: ignored. abort: any state -> IDLE next cycle, sclk=0, no done,
//   no further strobe; error flags keep value. abort and start same cycle in IDLE:
//   abort wins (stay IDLE).
//  dma_data/dma_addr hold last value between strobes; min strobe spacing 16*CLKDIV.
//  Error flags cleared only by reset_ or accepted start.
// TESTING
//  1. start; card sends 3x0xFF, 0xFE, 512x0x00, CRC 0x0000 -> 512 strobes addr 0..511
//     data 0x00, done pulse, all errors 0, busy falls with done.
//  2. 0xFE, 512x0xFF, CRC 0x7FA1 -> crc_error=0; repeat with CRC 0x7FA0 -> crc_error=1.
//  3. Data bytes = addr[7:0] -> each strobe's dma_data equals dma_addr[7:0]; strobe
//     spacing exactly 16*CLKDIV cycles for CLKDIV=2 and CLKDIV=1.
//  4. TOKEN_TIMEOUT=8, miso held 1 -> timeout_error=1 after 8 bytes, done, 0 strobes;
//     token 0x05 instead -> token_error=1, done, 0 strobes.
//  5. abort after 100 strobes -> IDLE next cycle, sclk 0, no done; new start then
//     full good block -> errors cleared, strobes restart at addr 0.
//  6. reset_ low mid-DATA (async, between clk edges) -> outputs at reset values
//     immediately; start during busy ignored (no restart of addr).

Source files
------------

// File: rtl/sdcard_block_reader.sv
// SPI-mode SD card single-block read engine.
// Once the command layer has issued CMD17, this block clocks the card and hunts
// for the 0xFE start token. It then shifts in 512 data bytes and the CRC16.
// Each data byte leaves as a one-cycle strobe with its byte address.
module sdcard_block_reader #(
  parameter int CLKDIV        = 2,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       start,
  input  logic       abort,
  output logic       sd_sclk,
  output logic       sd_mosi,
  input  logic       sd_miso,
  output logic [7:0] dma_data,
  output logic [8:0] dma_addr,
  output logic       dma_strobe,
  output logic       busy,
  output logic       done,
  output logic       crc_error,
  output logic       token_error,
  output logic       timeout_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TOKEN,
    S_DATA,
    S_CRC_HI,
    S_CRC_LO,
    S_DONE
  } state_t;

  localparam int               DIV_W    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [15:0]      TMO_LAST = 16'(TOKEN_TIMEOUT - 1);

  // CRC16-CCITT (poly 0x1021), one byte MSB-first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic [8:0]       addr_q, addr_d;
  logic             strobe_q, strobe_d;
  logic [8:0]       idx_q, idx_d;
  logic [15:0]      crc_q, crc_d;
  logic [7:0]       crc_hi_q, crc_hi_d;
  logic [15:0]      tmo_q, tmo_d;
  logic             crc_err_q, crc_err_d;
  logic             tok_err_q, tok_err_d;
  logic             tmo_err_q, tmo_err_d;

  logic       running;
  logic       tick;
  logic       rise;
  logic       byte_fire;
  logic [7:0] rx_byte;

  // The bit engine only runs while a transfer is in progress; a byte completes
  // on the 8th sclk rising edge, taking the current miso bit as its LSB.
  assign running   = (state_q == S_WAIT_TOKEN) || (state_q == S_DATA) ||
                     (state_q == S_CRC_HI)     || (state_q == S_CRC_LO);
  assign tick      = running && (div_q == DIV_LAST);
  assign rise      = tick && !sclk_q;
  assign byte_fire = rise && (bit_q == 3'd7);
  assign rx_byte   = {shift_q, sd_miso};

  // State register and all datapath/status registers
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      sclk_q    <= 1'b0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      strobe_q  <= 1'b0;
      idx_q     <= '0;
      crc_q     <= '0;
      crc_hi_q  <= '0;
      tmo_q     <= '0;
      crc_err_q <= 1'b0;
      tok_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      strobe_q  <= strobe_d;
      idx_q     <= idx_d;
      crc_q     <= crc_d;
      crc_hi_q  <= crc_hi_d;
      tmo_q     <= tmo_d;
      crc_err_q <= crc_err_d;
      tok_err_q <= tok_err_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // Next-state: sclk divider, byte assembly, and the read sequence
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    sclk_d    = sclk_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    addr_d    = addr_q;
    strobe_d  = 1'b0;
    idx_d     = idx_q;
    crc_d     = crc_q;
    crc_hi_d  = crc_hi_q;
    tmo_d     = tmo_q;
    crc_err_d = crc_err_q;
    tok_err_d = tok_err_q;
    tmo_err_d = tmo_err_q;

    if (running) begin
      if (tick) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (rise) begin
        shift_d = rx_byte[6:0];
        bit_d   = bit_q + 3'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WAIT_TOKEN;
          crc_err_d = 1'b0;
          tok_err_d = 1'b0;
          tmo_err_d = 1'b0;
          tmo_d     = '0;
          idx_d     = '0;
        end
      end
      S_WAIT_TOKEN: begin
        if (byte_fire) begin
          if (rx_byte == 8'hFE) begin
            state_d = S_DATA;
            idx_d   = '0;
            crc_d   = '0;
          end else if (rx_byte == 8'hFF) begin
            tmo_d = tmo_q + 16'd1;
            if (tmo_q == TMO_LAST) begin
              tmo_err_d = 1'b1;
              state_d   = S_DONE;
            end
          end else begin
            tok_err_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_DATA: begin
        if (byte_fire) begin
          data_d   = rx_byte;
          addr_d   = idx_q;
          strobe_d = 1'b1;
          crc_d    = crc16_byte(crc_q, rx_byte);
          idx_d    = idx_q + 9'd1;
          if (idx_q == 9'd511) state_d = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (byte_fire) begin
          crc_hi_d = rx_byte;
          state_d  = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (byte_fire) begin
          crc_err_d = ({crc_hi_q, rx_byte} != crc_q);
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything: no done, no strobe, flags untouched
    if (abort) begin
      state_d   = S_IDLE;
      strobe_d  = 1'b0;
      data_d    = data_q;
      addr_d    = addr_q;
      crc_err_d = crc_err_q;
      tok_err_d = tok_err_q;
      tmo_err_d = tmo_err_q;
    end

    // Park sclk low whenever the transfer ends or is cancelled
    if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
      sclk_d = 1'b0;
      div_d  = '0;
      bit_d  = '0;
    end
  end

  assign sd_sclk       = sclk_q;
  assign sd_mosi       = 1'b1;
  assign dma_data      = data_q;
  assign dma_addr      = addr_q;
  assign dma_strobe    = strobe_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign crc_error     = crc_err_q;
  assign token_error   = tok_err_q;
  assign timeout_error = tmo_err_q;

endmodule

// File: tb/tb_sdcard_block_reader.sv
// Bench for sdcard_block_reader: a bit-level SPI card model feeds byte streams,
// and a stream-level reference model predicts strobes, flags and duration.
module tb_sdcard_block_reader;

  localparam int TT     = 8;
  localparam int BUDGET = 20000;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_;
  logic       start, abort, sd_miso;
  logic       sd_sclk, sd_mosi, dma_strobe, busy, done;
  logic       crc_error, token_error, timeout_error;
  logic [7:0] dma_data;
  logic [8:0] dma_addr;

  logic       start_b, abort_b, miso_b;
  logic       sclk_b, mosi_b, strobe_b, busy_b, done_b;
  logic       crc_error_b, token_error_b, timeout_error_b;
  logic [7:0] data_b;
  logic [8:0] addr_b;

  sdcard_block_reader #(.CLKDIV(1), .TOKEN_TIMEOUT(TT)) u_dut (
    .clk(clk), .reset_(reset_), .start(start), .abort(abort),
    .sd_sclk(sd_sclk), .sd_mosi(sd_mosi), .sd_miso(sd_miso),
    .dma_data(dma_data), .dma_addr(dma_addr), .dma_strobe(dma_strobe),
    .busy(busy), .done(done), .crc_error(crc_error),
    .token_error(token_error), .timeout_error(timeout_error)
  );

  sdcard_block_reader #(.CLKDIV(2)) u_dut_b (
    .clk(clk), .reset_(reset_), .start(start_b), .abort(abort_b),
    .sd_sclk(sclk_b), .sd_mosi(mosi_b), .sd_miso(miso_b),
    .dma_data(data_b), .dma_addr(addr_b), .dma_strobe(strobe_b),
    .busy(busy_b), .done(done_b), .crc_error(crc_error_b),
    .token_error(token_error_b), .timeout_error(timeout_error_b)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Card models: shift MSB-first, change data on sclk falling edge, idle high
  bq_t card_a, card_b;
  int  bit_a, bit_b;

  task automatic load_a(input bq_t s);
    card_a  = s;
    bit_a   = 7;
    sd_miso = (card_a.size() > 0) ? card_a[0][bit_a] : 1'b1;
  endtask

  task automatic load_b(input bq_t s);
    card_b = s;
    bit_b  = 7;
    miso_b = (card_b.size() > 0) ? card_b[0][bit_b] : 1'b1;
  endtask

  always @(negedge sd_sclk) begin
    if (card_a.size() > 0) begin
      if (bit_a == 0) begin
        void'(card_a.pop_front());
        bit_a = 7;
      end else bit_a--;
    end
    sd_miso = (card_a.size() > 0) ? card_a[0][bit_a] : 1'b1;
  end

  always @(negedge sclk_b) begin
    if (card_b.size() > 0) begin
      if (bit_b == 0) begin
        void'(card_b.pop_front());
        bit_b = 7;
      end else bit_b--;
    end
    miso_b = (card_b.size() > 0) ? card_b[0][bit_b] : 1'b1;
  end

  // Output capture, sampled on the falling clk edge
  bq_t         got_d;
  logic [8:0]  got_a[$];
  int          got_t[$];
  int          got_tb[$];
  int          dones;

  always @(negedge clk) begin
    if (dma_strobe) begin
      got_d.push_back(dma_data);
      got_a.push_back(dma_addr);
      got_t.push_back(cycle);
    end
    if (done) dones++;
    if (strobe_b) got_tb.push_back(cycle);
  end

  // Reference: CRC as remainder of M(x)*x^16 mod (x^16+x^12+x^5+1)
  function automatic logic [15:0] crc_ref(input bq_t d);
    logic [15:0] r;
    logic        top;
    r = '0;
    for (int i = 0; i < d.size() + 2; i++) begin
      for (int k = 7; k >= 0; k--) begin
        top = r[15];
        r   = {r[14:0], (i < d.size()) ? d[i][k] : 1'b0};
        if (top) r = r ^ 16'h1021;
      end
    end
    return r;
  endfunction

  bq_t exp_data;
  bit  exp_tok, exp_tmo, exp_crc;
  int  exp_bytes;

  task automatic model(input bq_t s);
    int         idx;
    int         ffs;
    logic [7:0] b, hi, lo;
    idx = 0; ffs = 0;
    exp_data.delete();
    exp_tok = 0; exp_tmo = 0; exp_crc = 0;
    for (int n = 0; n < 70000; n++) begin
      b = (idx < s.size()) ? s[idx] : 8'hFF; idx++;
      if (b == 8'hFE) begin
        for (int j = 0; j < 512; j++) begin
          exp_data.push_back((idx < s.size()) ? s[idx] : 8'hFF); idx++;
        end
        hi = (idx < s.size()) ? s[idx] : 8'hFF; idx++;
        lo = (idx < s.size()) ? s[idx] : 8'hFF; idx++;
        exp_crc = ({hi, lo} != crc_ref(exp_data));
        break;
      end else if (b == 8'hFF) begin
        ffs++;
        if (ffs == TT) begin
          exp_tmo = 1;
          break;
        end
      end else begin
        exp_tok = 1;
        break;
      end
    end
    exp_bytes = idx;
  endtask

  task automatic run_block(input string tag, input bq_t s, input int restart_at);
    int n, t0, td;
    bit restarted;
    model(s);
    load_a(s);
    got_d.delete(); got_a.delete(); got_t.delete();
    dones = 0;
    @(negedge clk); start = 1'b1; t0 = cycle;
    @(negedge clk); start = 1'b0;
    n = 0; restarted = 0;
    while (!done && n < BUDGET) begin
      start = (restart_at >= 0) && !restarted && (got_d.size() >= restart_at);
      if (start) restarted = 1;
      @(negedge clk); n++;
    end
    start = 1'b0;
    td = cycle;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_elapsed"}, td - t0, 16 * exp_bytes);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_done_count"}, dones, 1);
    chk({tag, "_nstrobes"}, got_d.size(), exp_data.size());
    for (int i = 0; i < got_d.size() && i < exp_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_data[i]);
      chk($sformatf("%s_addr%0d", tag, i), got_a[i], i);
    end
    chk({tag, "_crc_error"}, crc_error, exp_crc);
    chk({tag, "_token_error"}, token_error, exp_tok);
    chk({tag, "_timeout_error"}, timeout_error, exp_tmo);
  endtask

  bq_t s, s3;
  int  n, cnt;

  initial begin
    reset_ = 1'b0; start = 1'b0; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    sd_miso = 1'b1; miso_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sd_sclk, 0);
    chk("rst_mosi", sd_mosi, 1);
    chk("rst_data", dma_data, 0);
    chk("rst_addr", dma_addr, 0);
    chk("rst_strobe", dma_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_errs", {crc_error, token_error, timeout_error}, 0);
    chk("rst_busy_b", busy_b, 0);
    reset_ = 1'b1;
    @(negedge clk);

    // abort wins over start in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", busy, 0);

    // Zero block after three idle bytes, with a start pulse mid-transfer
    s.delete();
    repeat (3) s.push_back(8'hFF);
    s.push_back(8'hFE);
    repeat (514) s.push_back(8'h00);
    run_block("t1", s, 200);

    // All-ones block, good then bad CRC
    s.delete();
    s.push_back(8'hFE);
    repeat (512) s.push_back(8'hFF);
    s.push_back(8'h7F); s.push_back(8'hA1);
    run_block("t2a", s, -1);
    chk("t2a_crc_flag", crc_error, 0);
    s[514] = 8'hA0;
    run_block("t2b", s, -1);
    chk("t2b_crc_flag", crc_error, 1);

    // Data equal to address, with strobe spacing
    s3.delete();
    s3.push_back(8'hFE);
    for (int i = 0; i < 512; i++) s3.push_back(8'(i));
    exp_data = s3[1:512];
    s3.push_back(crc_ref(exp_data) >> 8);
    s3.push_back(crc_ref(exp_data) & 16'hFF);
    run_block("t3", s3, -1);
    for (int i = 1; i < got_t.size(); i++)
      chk($sformatf("t3_spacing%0d", i), got_t[i] - got_t[i-1], 16);

    // Same stream into the CLKDIV=2 instance: spacing over the first strobes
    got_tb.delete();
    load_b(s3);
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    n = 0;
    while (got_tb.size() < 20 && n < BUDGET) begin
      @(negedge clk); n++;
    end
    chk("b_progress", got_tb.size() >= 20, 1);
    @(negedge clk); abort_b = 1'b1;
    @(negedge clk); abort_b = 1'b0;
    chk("b_abort_busy", busy_b, 0);
    chk("b_abort_sclk", sclk_b, 0);
    for (int i = 1; i < 20 && i < got_tb.size(); i++)
      chk($sformatf("b_spacing%0d", i), got_tb[i] - got_tb[i-1], 32);

    // Timeout with miso held high, then a bad token
    s.delete();
    run_block("t4_tmo", s, -1);
    chk("t4_tmo_flag", timeout_error, 1);
    s.delete();
    s.push_back(8'h05);
    run_block("t4_tok", s, -1);
    chk("t4_tok_flag", token_error, 1);
    repeat (4) @(negedge clk);
    chk("t4_tok_sticky", token_error, 1);

    // Abort after 100 strobes, then a clean block
    load_a(s3);
    got_d.delete(); got_a.delete(); got_t.delete();
    dones = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (got_d.size() < 100 && n < BUDGET) begin
      @(negedge clk); n++;
    end
    chk("t5_progress", got_d.size() >= 100, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_sclk", sd_sclk, 0);
    cnt = got_d.size();
    repeat (64) @(negedge clk);
    chk("t5_no_more_strobes", got_d.size(), cnt);
    chk("t5_no_done", dones, 0);
    chk("t5_still_idle", busy, 0);
    run_block("t5_good", s3, -1);

    // Randomized blocks: random preamble, data, token and CRC corruption
    for (int t = 0; t < 2; t++) begin
      s.delete();
      n = $urandom_range(0, 4);
      repeat (n) s.push_back(8'hFF);
      if (t == 1 && $urandom_range(0, 1) == 1) begin
        s.push_back(8'($urandom_range(0, 253)));
      end else begin
        exp_data.delete();
        for (int i = 0; i < 512; i++) exp_data.push_back(8'($urandom));
        s.push_back(8'hFE);
        s = {s, exp_data};
        cnt = crc_ref(exp_data);
        if ($urandom_range(0, 1) == 1) cnt = cnt ^ (1 << $urandom_range(0, 15));
        s.push_back(8'(cnt >> 8));
        s.push_back(8'(cnt));
      end
      run_block($sformatf("rnd%0d", t), s, -1);
    end

    // Asynchronous reset between clock edges in the middle of a block
    load_a(s3);
    got_d.delete(); got_a.delete(); got_t.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (got_d.size() < 10 && n < BUDGET) begin
      @(negedge clk); n++;
    end
    chk("t6_progress", got_d.size() >= 10, 1);
    #2 reset_ = 1'b0;
    #1;
    chk("t6_sclk", sd_sclk, 0);
    chk("t6_mosi", sd_mosi, 1);
    chk("t6_data", dma_data, 0);
    chk("t6_addr", dma_addr, 0);
    chk("t6_strobe", dma_strobe, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_errs", {crc_error, token_error, timeout_error}, 0);
    @(negedge clk); reset_ = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_idle_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
